// File: rtl/uart_sensor_requester.sv
// Host-side UART sensor requester: sends one 8N1 command byte, then receives
// a two-byte reply (response code, measurement) and reports it with a status.
module uart_sensor_requester #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_CLKS = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  output logic       tx,
  input  logic       rx,
  output logic       rsp_valid,
  output logic [7:0] rsp_code,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_B0, RECV_B0, WAIT_B1, RECV_B1, DONE
  } state_t;

  state_t        state, state_nx;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [TW-1:0] to_cnt;
  logic [8:0]    tx_frame;
  logic          tx_q;
  logic [7:0]    cmd_q;
  logic [7:0]    rx_byte;

  logic accept, rx_fall, bit_end, rx_sample, in_wait, in_recv;
  logic glitch, frame_done, code_ok;

  always_comb begin
    accept     = req_valid && (state == IDLE);
    rx_fall    = rx_prev && !rx_s2;
    bit_end    = (clk_cnt == BIT_LAST);
    // start bit is checked at its centre, data/stop bits a full bit later
    rx_sample  = (bit_idx == 4'd0) ? (clk_cnt == HALF_LAST) : bit_end;
    in_wait    = (state == WAIT_B0) || (state == WAIT_B1);
    in_recv    = (state == RECV_B0) || (state == RECV_B1);
    glitch     = in_recv && rx_sample && (bit_idx == 4'd0) && rx_s2;
    frame_done = in_recv && rx_sample && (bit_idx == 4'd9);
    code_ok    = ((cmd_q == 8'h04) && (rsp_code == 8'h02)) ||
                 ((cmd_q == 8'h05) && (rsp_code == 8'h01));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SEND;
      SEND:    if (bit_end && (bit_idx == 4'd9)) state_nx = WAIT_B0;
      WAIT_B0: begin
        if (rx_fall)                 state_nx = RECV_B0;
        else if (to_cnt == TO_LAST)  state_nx = DONE;
      end
      RECV_B0: begin
        if (glitch)          state_nx = WAIT_B0;
        else if (frame_done) state_nx = rx_s2 ? WAIT_B1 : DONE;
      end
      WAIT_B1: begin
        if (rx_fall)                 state_nx = RECV_B1;
        else if (to_cnt == TO_LAST)  state_nx = DONE;
      end
      RECV_B1: begin
        if (glitch)          state_nx = WAIT_B1;
        else if (frame_done) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Synchroniser and edge-detect history idle high so reset never fakes a start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      to_cnt   <= '0;
      tx_frame <= '1;
      tx_q     <= 1'b1;
      cmd_q    <= '0;
      rx_byte  <= '0;
      rsp_code <= '0;
      rsp_data <= '0;
      rsp_err  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cmd_q    <= req_cmd;
          tx_frame <= {1'b1, req_cmd};
          tx_q     <= 1'b0;
          clk_cnt  <= '0;
          bit_idx  <= '0;
          rsp_code <= '0;
          rsp_data <= '0;
          rsp_err  <= '0;
        end
        SEND: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              to_cnt  <= '0;
              tx_q    <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              tx_q     <= tx_frame[0];
              tx_frame <= {1'b1, tx_frame[8:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        WAIT_B0, WAIT_B1: begin
          // the timeout keeps its value across a rejected glitch
          if (rx_fall) begin
            clk_cnt <= '0;
            bit_idx <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TO_LAST) rsp_err <= 2'b01;
          end
        end
        RECV_B0, RECV_B1: begin
          if (rx_sample) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd0) begin
              if (!rx_s2) bit_idx <= 4'd1;
            end else if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (!rx_s2) begin
                rsp_err <= 2'b10;
              end else if (state == RECV_B0) begin
                rsp_code <= rx_byte;
                to_cnt   <= '0;
              end else begin
                rsp_data <= rx_byte;
                if (!code_ok) rsp_err <= 2'b11;
              end
            end else begin
              rx_byte <= {rx_s2, rx_byte[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tx        = tx_q;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

endmodule
